branch_seq: RTL and testbench
=============================

# branch_seq

Multi-cycle control sequencer for conditional branches (brzr/brnz/brpl/brmi). It drives the datapath strobes that feed the CON flip-flop logic and consumes the registered CON result to decide whether the PC loads the branch target. It sits in the control unit between instruction decode and the register file/PC, on the opposite side of the CON interface from the condition evaluator.

## Interface
Parameters:
- DATA_W, 32, datapath/bus width.
- CNT_W, 16, width of statistics counters (used only with stats enabled).

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  decode asserts for one cycle when a branch instruction is in IR.
- ir  in  DATA_W  instruction register; ir[20:19] is the condition field C2.
- con  in  1  registered CON flip-flop output.
- cond  out  2  condition field held stable to the CON logic for the whole sequence.
- gra  out  1  select Ra field for register-file read.
- grb  out  1  select Rb field for register-file read.
- r_out  out  1  register file drives bus.
- con_ld  out  1  CON flip-flop load strobe.
- pc_ld  out  1  PC loads from bus.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- taken  out  1  valid with done: branch was taken.
- taken_cnt, nottaken_cnt  out  CNT_W each  statistics (stats build only).

## Operation
- States: IDLE, EVAL, RESOLVE, DONE.
- IDLE: all strobes 0; on start=1, latch ir[20:19] into cond, go to EVAL.
- EVAL: gra=1, r_out=1, con_ld=1 (Ra value on bus, CON captures condition on this edge). Next: RESOLVE.
- RESOLVE: grb=1, r_out=1 (Rb target on bus); pc_ld=con combinationally from the now-valid con. Latch taken=con. Next: DONE.
- DONE: done=1, taken valid; strobes 0. Next: IDLE.
- C2 encoding: 00 brzr (Ra==0), 01 brnz (Ra!=0), 10 brpl (Ra[31]==0), 11 brmi (Ra[31]==1); evaluation itself is external, block only holds cond.
- start while busy: ignored, no queueing.
- cond changes only on accepted start; ir changes mid-sequence have no effect.

## Timing
- Reset (async, any state): state=IDLE; cond=00, taken=0, busy=0, done=0, all strobes 0, counters 0.
- Clear mid-sequence: pc_ld never asserts afterwards for that sequence; no done pulse.
- start sampled at edge N (in IDLE) -> EVAL during cycle N+1, RESOLVE N+2, DONE N+3; back to IDLE N+4, earliest next start accepted at edge N+4.
- busy=1 in EVAL, RESOLVE, DONE.
- pc_ld asserted at most one cycle per sequence, only in RESOLVE.
- All outputs except pc_ld are registered-state decodes (glitch-free Moore); pc_ld is Mealy on con.

## Configuration
- BRANCH_STATS_EN defined: taken_cnt/nottaken_cnt increment in DONE per outcome, saturate at all-ones (no wrap), cleared by clr.
- Undefined: counter ports still exist, tied to 0; no counter logic.

## Structure
- Package branch_pkg: state enum (IDLE, EVAL, RESOLVE, DONE), C2 constants (BRZR=00, BRNZ=01, BRPL=10, BRMI=11), C2 bit-slice localparams (20:19).
- One sub-module: sat_counter (CNT_W, clk, clr, inc, q) instantiated twice under BRANCH_STATS_EN.

## Test plan
- brzr, Ra=0, CON model returns 1 -> con_ld in EVAL, pc_ld=1 in RESOLVE, done+taken=1 at N+3, taken_cnt=1.
- brnz, Ra=0 -> con=0, pc_ld never asserted, taken=0, nottaken_cnt=1.
- brmi with Ra=-10 then brpl with Ra=-10 back-to-back (start at N+4) -> taken=1 then taken=0; cond shows 11 then 10.
- start pulsed again during EVAL and ir changed to C2=00 -> ignored, cond stays, single done.
- clr asserted asynchronously in RESOLVE mid-cycle -> all outputs 0 immediately, no done, next start works normally.
- With BRANCH_STATS_EN, CNT_W=2: five taken branches -> taken_cnt saturates at 3; without macro counters read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// ============================================================================
// Module   : branch_pkg
// Purpose  : Shared types and constants for the conditional-branch sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // C2 condition-field encodings carried to the external CON evaluator
  localparam logic [1:0] BRZR = 2'b00;
  localparam logic [1:0] BRNZ = 2'b01;
  localparam logic [1:0] BRPL = 2'b10;
  localparam logic [1:0] BRMI = 2'b11;

  localparam int C2_HI = 20;
  localparam int C2_LO = 19;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones; asynchronous clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/branch_seq.sv
// ============================================================================
// Module   : branch_seq
// Purpose  : Control sequencer for brzr/brnz/brpl/brmi; drives CON-load and
//            register strobes, then loads the PC from the registered CON.
//            Optional macro BRANCH_STATS_EN adds taken/not-taken counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_seq
  import branch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic              con,
  output logic [1:0]        cond,
  output logic              gra,
  output logic              grb,
  output logic              r_out,
  output logic              con_ld,
  output logic              pc_ld,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nottaken_cnt
);

  state_e     state_q;
  logic [1:0] cond_q;
  logic       taken_q;
  logic       gra_q;
  logic       grb_q;
  logic       r_out_q;
  logic       con_ld_q;
  logic       busy_q;
  logic       done_q;

  // Only the C2 field of the instruction matters to this block.
  logic unused_ir;
  assign unused_ir = ^{ir[DATA_W-1:C2_HI+1], ir[C2_LO-1:0]};

  // Strobes are computed one edge early so each output is a plain flop.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cond_q   <= 2'b00;
      taken_q  <= 1'b0;
      gra_q    <= 1'b0;
      grb_q    <= 1'b0;
      r_out_q  <= 1'b0;
      con_ld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      gra_q    <= 1'b0;
      grb_q    <= 1'b0;
      r_out_q  <= 1'b0;
      con_ld_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= EVAL;
            cond_q   <= ir[C2_HI:C2_LO];
            gra_q    <= 1'b1;
            r_out_q  <= 1'b1;
            con_ld_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        EVAL: begin
          state_q <= RESOLVE;
          grb_q   <= 1'b1;
          r_out_q <= 1'b1;
        end
        RESOLVE: begin
          state_q <= DONE;
          taken_q <= con;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // CON was loaded at the end of EVAL, so it is valid throughout RESOLVE.
  assign pc_ld  = (state_q == RESOLVE) & con;

  assign cond   = cond_q;
  assign gra    = gra_q;
  assign grb    = grb_q;
  assign r_out  = r_out_q;
  assign con_ld = con_ld_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign taken  = taken_q;

`ifdef BRANCH_STATS_EN
  logic inc_taken;
  logic inc_nottaken;

  assign inc_taken    = done_q &  taken_q;
  assign inc_nottaken = done_q & ~taken_q;

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .clr (clr),
    .inc (inc_taken),
    .q   (taken_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_nottaken_cnt (
    .clk (clk),
    .clr (clr),
    .inc (inc_nottaken),
    .q   (nottaken_cnt)
  );
`else
  assign taken_cnt    = '0;
  assign nottaken_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_seq.sv
// ============================================================================
// Module   : tb_branch_seq
// Purpose  : Self-checking bench for branch_seq with an external CON model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_seq;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic [DATA_W-1:0] ir;
  logic              con;
  logic [1:0]        cond;
  logic              gra, grb, r_out, con_ld, pc_ld, busy, done, taken;
  logic [CNT_W-1:0]  taken_cnt, nottaken_cnt;

  logic [31:0] ra;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [2:0]  sb[$];
  int          exp_tk = 0;
  int          exp_ntk = 0;
  logic [6:0]  strobes;

  assign strobes = {gra, grb, r_out, con_ld, pc_ld, busy, done};

  branch_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .ir           (ir),
    .con          (con),
    .cond         (cond),
    .gra          (gra),
    .grb          (grb),
    .r_out        (r_out),
    .con_ld       (con_ld),
    .pc_ld        (pc_ld),
    .busy         (busy),
    .done         (done),
    .taken        (taken),
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic con_eval(input logic [1:0] c, input logic [31:0] v);
    case (c)
      2'b00:   return (v == 32'd0);
      2'b01:   return (v != 32'd0);
      2'b10:   return ~v[31];
      default: return v[31];
    endcase
  endfunction

  // External CON flip-flop: evaluates the held condition against Ra on con_ld.
  always @(posedge clk or posedge clr) begin
    if (clr) con <= 1'b0;
    else if (con_ld) con <= con_eval(cond, ra);
  end

  function automatic int exp_cnt(input int c);
    return STATS ? c : 0;
  endfunction

  task automatic check_counts(input string name);
    n_cmp++;
    if (taken_cnt !== CNT_W'(exp_cnt(exp_tk)) || nottaken_cnt !== CNT_W'(exp_cnt(exp_ntk))) begin
      n_bad++;
      $display("FAIL %s counters: got tk=%0d ntk=%0d want tk=%0d ntk=%0d",
               name, taken_cnt, nottaken_cnt, exp_cnt(exp_tk), exp_cnt(exp_ntk));
    end
  endtask

  task automatic pop_and_check_done(input string name);
    logic [2:0] e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s done: got unexpected completion want none", name);
    end else begin
      e = sb.pop_front();
      if (strobes !== 7'b0000011 || {taken, cond} !== e) begin
        n_bad++;
        $display("FAIL %s done: got strobes=%b taken/cond=%b want strobes=0000011 taken/cond=%b",
                 name, strobes, {taken, cond}, e);
      end
      if (e[2]) begin if (exp_tk < CNT_MAX) exp_tk++; end
      else begin if (exp_ntk < CNT_MAX) exp_ntk++; end
    end
  endtask

  // One full branch; on return the DUT is in IDLE, one cycle after DONE.
  task automatic do_seq(input string name, input logic [1:0] c2, input logic [31:0] v);
    logic t;
    t = con_eval(c2, v);
    ir = $urandom;
    ir[20:19] = c2;
    ra = v;
    start = 1'b1;
    sb.push_back({t, c2});
    @(posedge clk); #1;
    start = 1'b0;
    ir = $urandom;
    n_cmp++;
    if (strobes !== 7'b1011010 || cond !== c2) begin
      n_bad++;
      $display("FAIL %s eval: got strobes=%b cond=%b want strobes=1011010 cond=%b",
               name, strobes, cond, c2);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (strobes !== {4'b0110, t, 2'b10} || cond !== c2) begin
      n_bad++;
      $display("FAIL %s resolve: got strobes=%b cond=%b want strobes=%b cond=%b",
               name, strobes, cond, {4'b0110, t, 2'b10}, c2);
    end
    @(posedge clk); #1;
    pop_and_check_done(name);
    @(posedge clk); #1;
    n_cmp++;
    if (strobes !== 7'b0000000) begin
      n_bad++;
      $display("FAIL %s idle: got strobes=%b want 0000000", name, strobes);
    end
    check_counts(name);
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; ir = '0; ra = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (strobes !== 7'b0 || cond !== 2'b00 || taken !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got strobes=%b cond=%b taken=%b want all 0", strobes, cond, taken);
    end
    check_counts("reset");
    clr = 1'b0;
  endtask

  task automatic test_taken();
    do_seq("brzr_ra0", 2'b00, 32'd0);
    do_seq("brpl_pos", 2'b10, 32'd7);
  endtask

  task automatic test_nottaken();
    do_seq("brnz_ra0", 2'b01, 32'd0);
    do_seq("brzr_ra5", 2'b00, 32'd5);
  endtask

  task automatic test_back_to_back();
    do_seq("brmi_neg", 2'b11, -32'sd10);
    do_seq("brpl_neg", 2'b10, -32'sd10);
  endtask

  task automatic test_ignore_start();
    ir = '0; ir[20:19] = 2'b01; ra = 32'd5; start = 1'b1;
    sb.push_back({1'b1, 2'b01});
    @(posedge clk); #1;
    ir[20:19] = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (strobes !== 7'b0110110 || cond !== 2'b01) begin
      n_bad++;
      $display("FAIL ignore resolve: got strobes=%b cond=%b want 0110110 cond=01", strobes, cond);
    end
    @(posedge clk); #1;
    pop_and_check_done("ignore");
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if (strobes !== 7'b0 || cond !== 2'b01) begin
        n_bad++;
        $display("FAIL ignore idle: got strobes=%b cond=%b want 0000000 cond=01", strobes, cond);
      end
    end
    check_counts("ignore");
  endtask

  task automatic test_clear_mid();
    logic bad;
    ir = '0; ir[20:19] = 2'b00; ra = 32'd0; start = 1'b1;
    sb.push_back({1'b1, 2'b00});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (pc_ld !== 1'b1) begin
      n_bad++;
      $display("FAIL clr pre pc_ld: got %b want 1", pc_ld);
    end
    #2 clr = 1'b1;
    #1;
    n_cmp++;
    if (strobes !== 7'b0 || cond !== 2'b00 || taken !== 1'b0) begin
      n_bad++;
      $display("FAIL clr async: got strobes=%b cond=%b taken=%b want all 0", strobes, cond, taken);
    end
    sb.delete();
    exp_tk = 0; exp_ntk = 0;
    check_counts("clr");
    #1 clr = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || pc_ld !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL clr quiet: got done/pc_ld/busy activity want none");
    end
    do_seq("after_clr", 2'b00, 32'd0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) do_seq("sat", 2'b11, 32'h8000_0001);
    n_cmp++;
    if (taken_cnt !== (STATS ? CNT_W'(CNT_MAX) : CNT_W'(0))) begin
      n_bad++;
      $display("FAIL saturate: got taken_cnt=%0d want %0d", taken_cnt, STATS ? CNT_MAX : 0);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_taken();
    test_nottaken();
    test_back_to_back();
    test_ignore_start();
    test_clear_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
